// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: next-PC source codes,
// default PC width and the target alignment mask helper.
package pc_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [1:0] SRC_SEQ   = 2'd0;
  localparam logic [1:0] SRC_PEND  = 2'd1;
  localparam logic [1:0] SRC_REDIR = 2'd2;
  localparam logic [1:0] SRC_TRAP  = 2'd3;

  // 64-bit wide so any XLEN up to 64 can slice the mask it needs.
  function automatic logic [63:0] align_mask(input int unsigned bits);
    return ~((64'd1 << bits) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_hist.sv
// PC history shift register: entry 0 is youngest. Shifts on enable, flush clears
// all valid bits while data still follows the enable.
module pc_hist_shift #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic [W-1:0]       din_i,
  output logic [DEPTH*W-1:0] hist_o,
  output logic [DEPTH-1:0]   valid_o
);

  logic [DEPTH-1:0][W-1:0] hist_q;
  logic [DEPTH-1:0]        valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      valid_q <= '0;
    end else begin
      if (en_i) begin
        hist_q[0] <= din_i;
        for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
      end
      if (flush_i) begin
        valid_q <= '0;
      end else if (en_i) begin
        valid_q[0] <= 1'b1;
        for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign hist_o  = hist_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC: trap > redirect > pending > sequential next-PC select, sticky
// pending redirect across stalls, misalignment pulse and a short PC history.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     PIPE_DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stallF,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       trap_valid,
  input  logic [XLEN-1:0]            trap_pc,
  output logic [XLEN-1:0]            PCF_out,
  output logic [XLEN-1:0]            PCPlusIncF,
  output logic                       pending_out,
  output logic                       misalign_err,
  output logic [PIPE_DEPTH*XLEN-1:0] pc_hist,
  output logic [PIPE_DEPTH-1:0]      hist_valid
);

  localparam logic [63:0]     AMASK64 = align_mask(ALIGN_BITS);
  localparam logic [XLEN-1:0] AMASK   = AMASK64[XLEN-1:0];

  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic            pend_q, pend_d, mis_q, mis_d;
  logic [1:0]      src_sel;
  logic [XLEN-1:0] req_tgt, req_aligned, next_pc;
  logic            req_any, taken, hist_flush;

  assign req_any     = trap_valid | redirect_valid;
  assign req_tgt     = trap_valid ? trap_pc : redirect_pc;
  assign req_aligned = req_tgt & AMASK;
  assign PCPlusIncF  = pc_q + XLEN'(INC);

  always_comb begin
    if (trap_valid)          src_sel = SRC_TRAP;
    else if (redirect_valid) src_sel = SRC_REDIR;
    else if (pend_q)         src_sel = SRC_PEND;
    else                     src_sel = SRC_SEQ;
  end

  // The sequential path is deliberately left unaligned.
  always_comb begin
    case (src_sel)
      SRC_TRAP, SRC_REDIR: next_pc = req_aligned;
      SRC_PEND:            next_pc = pend_pc_q;
      default:             next_pc = PCPlusIncF;
    endcase
  end

  assign taken = (src_sel != SRC_SEQ);

  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    mis_d     = req_any && ((req_tgt & ~AMASK) != '0);
    if (!stallF) begin
      pc_d   = next_pc;
      pend_d = 1'b0;
    end else if (req_any) begin
      pend_d    = 1'b1;
      pend_pc_d = req_aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      mis_q     <= mis_d;
    end
  end

  assign hist_flush = stallF ? req_any : taken;

  pc_hist_shift #(.DEPTH(PIPE_DEPTH), .W(XLEN)) u_hist (
    .clk     (clk),
    .reset   (reset),
    .en_i    (!stallF),
    .flush_i (hist_flush),
    .din_i   (pc_q),
    .hist_o  (pc_hist),
    .valid_o (hist_valid)
  );

  assign PCF_out      = pc_q;
  assign pending_out  = pend_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes model expectations per
// cycle, an independent monitor pops and compares after each clock edge.
module tb_pc_fetch_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned D    = 2;
  localparam logic [31:0] RV   = 32'h100;

  logic            clk = 1'b0;
  logic            reset, stallF, redirect_valid, trap_valid;
  logic [31:0]     redirect_pc, trap_pc;
  logic [31:0]     PCF_out, PCPlusIncF;
  logic            pending_out, misalign_err;
  logic [D*32-1:0] pc_hist;
  logic [D-1:0]    hist_valid;

  pc_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .INC(4), .ALIGN_BITS(2), .PIPE_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .stallF(stallF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .PCF_out(PCF_out), .PCPlusIncF(PCPlusIncF), .pending_out(pending_out),
    .misalign_err(misalign_err), .pc_hist(pc_hist), .hist_valid(hist_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        mis;
    logic [31:0] h0, h1;
    logic [1:0]  hv;
  } exp_t;

  exp_t exp_q[$];
  int ncmp = 0, nerr = 0;
  bit done = 0;

  // Reference model: fetched-PC list plus a run length of clean sequential fetches.
  logic [31:0] m_pc, m_ppc;
  bit          m_pend, m_mis;
  logic [31:0] m_fetched[$];
  int          m_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, st, rv, input logic [31:0] rpc,
                            input bit tv, input logic [31:0] tpc);
    logic [31:0] tgt;
    bit req;
    if (rst) begin
      m_pc = RV; m_pend = 0; m_ppc = '0; m_mis = 0; m_run = 0;
      m_fetched = '{32'h0, 32'h0};
      return;
    end
    req   = tv || rv;
    tgt   = tv ? tpc : rpc;
    m_mis = req && (tgt % 4 != 0);
    if (!st) begin
      m_fetched.push_front(m_pc);
      void'(m_fetched.pop_back());
      m_run = (req || m_pend) ? 0 : ((m_run < D) ? m_run + 1 : D);
      if (req)         m_pc = tgt - (tgt % 4);
      else if (m_pend) m_pc = m_ppc;
      else             m_pc = m_pc + 4;
      m_pend = 0;
    end else if (req) begin
      m_pend = 1;
      m_ppc  = tgt - (tgt % 4);
      m_run  = 0;
    end
  endtask

  task automatic step(input bit rst, st, rv, input logic [31:0] rpc,
                      input bit tv, input logic [31:0] tpc);
    exp_t e;
    @(negedge clk);
    reset = rst; stallF = st; redirect_valid = rv; redirect_pc = rpc;
    trap_valid = tv; trap_pc = tpc;
    @(posedge clk);
    model_step(rst, st, rv, rpc, tv, tpc);
    e.pc = m_pc; e.pend = m_pend; e.mis = m_mis;
    e.h0 = m_fetched[0]; e.h1 = m_fetched[1];
    e.hv = {m_run >= 2, m_run >= 1};
    exp_q.push_back(e);
  endtask

  task automatic free(); step(0, 0, 0, 0, 0, 0); endtask

  // Monitor: one expectation per clock edge once the stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc",       PCF_out,             e.pc);
        chk("pcplus",   PCPlusIncF,          e.pc + 32'd4);
        chk("pending",  32'(pending_out),    32'(e.pend));
        chk("misalign", 32'(misalign_err),   32'(e.mis));
        chk("hist_valid", 32'(hist_valid),   32'(e.hv));
        chk("hist0",    pc_hist[31:0],       e.h0);
        chk("hist1",    pc_hist[63:32],      e.h1);
      end
    end
  end

  initial begin
    reset = 1; stallF = 0; redirect_valid = 0; trap_valid = 0;
    redirect_pc = '0; trap_pc = '0;
    m_fetched = '{32'h0, 32'h0};
    m_pc = RV; m_pend = 0; m_ppc = '0; m_mis = 0; m_run = 0;

    step(1, 0, 0, 0, 0, 0);
    #2 chk("d_reset_pc", PCF_out, 32'h100); chk("d_reset_hv", 32'(hist_valid), 0);
    free(); #2 chk("d_pc104", PCF_out, 32'h104);
    free(); #2 chk("d_pc108", PCF_out, 32'h108); chk("d_hv11", 32'(hist_valid), 32'h3);
    free(); #2 chk("d_pc10c", PCF_out, 32'h10C);
    step(0, 0, 1, 32'h200, 0, 0); #2 chk("d_redir", PCF_out, 32'h200); chk("d_flush", 32'(hist_valid), 0);
    free(); #2 chk("d_pc204", PCF_out, 32'h204); chk("d_hv01", 32'(hist_valid), 32'h1);
    step(0, 1, 1, 32'h300, 0, 0); #2 chk("d_stall_hold", PCF_out, 32'h204); chk("d_pend", 32'(pending_out), 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0); #2 chk("d_still_pend", 32'(pending_out), 1);
    free(); #2 chk("d_release", PCF_out, 32'h300); chk("d_pend_clr", 32'(pending_out), 0);
    step(0, 1, 1, 32'h300, 0, 0);
    step(0, 0, 0, 0, 1, 32'h80); #2 chk("d_trap_beats_pend", PCF_out, 32'h80); chk("d_pend_drop", 32'(pending_out), 0);
    free(); #2 chk("d_no_stale_pend", PCF_out, 32'h84);
    step(0, 0, 1, 32'h500, 1, 32'h600); #2 chk("d_trap_prio", PCF_out, 32'h600);
    step(0, 0, 1, 32'h403, 0, 0); #2 chk("d_align", PCF_out, 32'h400); chk("d_mis", 32'(misalign_err), 1);
    free(); #2 chk("d_mis_pulse", 32'(misalign_err), 0);
    step(0, 0, 1, 32'hFFFFFFF8, 0, 0);
    free(); #2 chk("d_pcfc", PCF_out, 32'hFFFFFFFC);
    free(); #2 chk("d_wrap", PCF_out, 32'h0); chk("d_wrap_nomis", 32'(misalign_err), 0);
    step(0, 1, 0, 0, 1, 32'h701); #2 chk("d_cap_mis", 32'(misalign_err), 1);
    step(0, 1, 0, 0, 0, 0); #2 chk("d_cap_mis_once", 32'(misalign_err), 0);
    step(1, 1, 0, 0, 0, 0); #2 chk("d_rst_pc", PCF_out, 32'h100); chk("d_rst_pend", 32'(pending_out), 0);
    chk("d_rst_hv", 32'(hist_valid), 0);

    for (int n = 0; n < 600; n++) begin
      bit r, s, rv, tv;
      logic [31:0] rp, tp;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 35);
      rv = ($urandom_range(0, 99) < 20);
      tv = ($urandom_range(0, 99) < 8);
      rp = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom;
      tp = $urandom;
      step(r, s, rv, rp, tv, tp);
    end
    @(negedge clk);
    redirect_valid = 0; trap_valid = 0; stallF = 0; reset = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    done = 1;
  end

  initial begin
    fork
      wait (done);
      begin
        #200000;
        nerr++;
        $display("FAIL timeout: bench did not complete in time");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
